// File: rtl/databus_mem_responder.sv
// Databus target: word-organised scratch memory with programmable wait
// states and read/write/error transfer counters.
module databus_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int WAIT_W     = 4,
    parameter int CNT_W      = 16,
    parameter int IO_ADDR_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WAIT_W-1:0]     wait_cycles,
    input  logic                  cnt_clr,
    input  logic                  databus_valid,
    input  logic [IO_ADDR_W-1:0]  databus_addr,
    input  logic [DATA_W-1:0]     databus_wdata,
    input  logic [DATA_W/8-1:0]   databus_wstrb,
    output logic                  databus_ready,
    output logic [DATA_W-1:0]     databus_rdata,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  busy
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int OOR_LSB  = ADDR_LSB + MEM_ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_n;
    logic [WAIT_W-1:0]     wait_q;
    logic [MEM_ADDR_W-1:0] word_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  oor_q;

    logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];

    logic [MEM_ADDR_W-1:0] in_word;
    logic                  in_oor;
    logic [MEM_ADDR_W-1:0] rd_word;
    logic                  rd_oor;

    // Any address bit above the memory window marks the access out-of-range.
    assign in_word = databus_addr[ADDR_LSB +: MEM_ADDR_W];
    assign in_oor  = |(databus_addr >> OOR_LSB);

    // With zero wait states RESP is entered straight from IDLE, before the
    // request has been latched, so the read must use the live bus then.
    assign rd_word = (state == IDLE) ? in_word : word_q;
    assign rd_oor  = (state == IDLE) ? in_oor  : oor_q;

    assign busy = (state != IDLE);

    // State register, wait-state countdown and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wait_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (databus_valid) begin
                    word_q  <= in_word;
                    wdata_q <= databus_wdata;
                    wstrb_q <= databus_wstrb;
                    oor_q   <= in_oor;
                    wait_q  <= wait_cycles;
                end
                WAIT:    wait_q <= wait_q - WAIT_W'(1);
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (databus_valid) state_n = (wait_cycles != '0) ? WAIT : RESP;
            WAIT:    if (wait_q == WAIT_W'(1)) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered response: ready and read data are set on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            databus_ready <= 1'b0;
            databus_rdata <= '0;
        end else begin
            databus_ready <= (state_n == RESP);
            if (state_n == RESP)
                databus_rdata <= rd_oor ? '0 : mem[rd_word];
        end
    end

    // Byte-masked write on the RESP edge; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (state == RESP && !oor_q) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb_q[b])
                    mem[word_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
    end

    // Transfer counters: one increment per completed transaction, clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (cnt_clr) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (state == RESP) begin
            if (oor_q)             err_cnt <= err_cnt + CNT_W'(1);
            else if (|wstrb_q)     wr_cnt  <= wr_cnt  + CNT_W'(1);
            else                   rd_cnt  <= rd_cnt  + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_databus_mem_responder.sv
// Scoreboard bench: the driver queues the expected ready cycle and read data
// per transaction, a negedge monitor pops and compares on every ready pulse.
module tb_databus_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wait_cycles;
    logic        cnt_clr;
    logic        databus_valid;
    logic [31:0] databus_addr;
    logic [31:0] databus_wdata;
    logic [3:0]  databus_wstrb;
    logic        databus_ready;
    logic [31:0] databus_rdata;
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          at;
        logic [31:0] rd;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    databus_mem_responder dut (
        .clk(clk), .rst(rst), .wait_cycles(wait_cycles), .cnt_clr(cnt_clr),
        .databus_valid(databus_valid), .databus_addr(databus_addr),
        .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
        .databus_ready(databus_ready), .databus_rdata(databus_rdata),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle index; inputs driven #1 after an edge belong to this cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && databus_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.at) begin
                    errors++;
                    $display("FAIL ready_cycle got %0d want %0d", cyc, e.at);
                end
                if (e.chk) begin
                    checks++;
                    if (databus_rdata !== e.rd) begin
                        errors++;
                        $display("FAIL rdata got %h want %h", databus_rdata, e.rd);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Called #1 after a posedge with the DUT in IDLE; returns likewise.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int w, input logic [31:0] exp_rd, input bit keep);
        exp_t e;
        int   n;
        databus_addr  = a;
        databus_wdata = d;
        databus_wstrb = s;
        databus_valid = 1'b1;
        e.at  = cyc + 1 + w;
        e.rd  = exp_rd;
        e.chk = (s == 4'h0);
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!databus_ready && n < 40);
        if (!databus_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout addr %h got 0 want 1", a);
        end
        @(posedge clk); #1;
        if (!keep) databus_valid = 1'b0;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wait_cycles = '0; cnt_clr = 1'b0; databus_valid = 1'b0;
        databus_addr = '0; databus_wdata = '0; databus_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(databus_ready), 32'h0);
        check("rst_rdata", databus_rdata, 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_cnts",  {rd_cnt | wr_cnt | err_cnt, 16'h0}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: full write then read, no wait states
        txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);
        txn(32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t1_rd_cnt", 32'(rd_cnt), 32'd1);

        // 2: low-half strobe merges with existing word
        txn(32'h10, 32'h12345678, 4'h3, 0, 32'h0, 0);
        txn(32'h10, 32'h0, 4'h0, 0, 32'hDEAD5678, 0);

        // 3: three wait states; shrinking wait_cycles mid-flight has no effect
        wait_cycles = 4'd3;
        fork
            txn(32'h10, 32'h0, 4'h0, 3, 32'hDEAD5678, 0);
            begin
                check("t3_busy_t0", 32'(busy), 32'h0);
                for (int k = 1; k <= 5; k++) begin
                    @(posedge clk); #1;
                    if (k == 2) wait_cycles = 4'd0;
                    check($sformatf("t3_busy_t%0d", k), 32'(busy), (k <= 4) ? 32'h1 : 32'h0);
                end
            end
        join

        // 4: out-of-range read and write alias word 0 but must not touch it
        txn(32'h0, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 0);
        clear_counters();
        txn(32'h1000, 32'h0, 4'h0, 0, 32'h0, 0);
        txn(32'h1000, 32'h55, 4'hF, 0, 32'h0, 0);
        check("t4_err_cnt", 32'(err_cnt), 32'd2);
        check("t4_wr_cnt",  32'(wr_cnt),  32'd0);
        txn(32'h0, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 0);

        // 5: preload words 0..7, then stream reads with valid held high
        for (int i = 0; i < 8; i++) txn(32'(i * 4), 32'(i), 4'hF, 0, 32'h0, 0);
        clear_counters();
        for (int i = 0; i < 8; i++) txn(32'(i * 4), 32'h0, 4'h0, 0, 32'(i), i < 7);
        check("t5_rd_cnt", 32'(rd_cnt), 32'd8);

        // 6a: reset during the wait phase of a write aborts it
        txn(32'h40, 32'h11111111, 4'hF, 0, 32'h0, 0);
        wait_cycles   = 4'd5;
        databus_addr  = 32'h40;
        databus_wdata = 32'hFFFFFFFF;
        databus_wstrb = 4'hF;
        databus_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; databus_valid = 1'b0; wait_cycles = 4'd0;
        #1;
        check("t6_rst_busy",  32'(busy), 32'h0);
        check("t6_rst_ready", 32'(databus_ready), 32'h0);
        check("t6_rst_cnts",  {rd_cnt | wr_cnt | err_cnt, 16'h0}, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(32'h40, 32'h0, 4'h0, 0, 32'h11111111, 0);
        check("t6_rd_cnt", 32'(rd_cnt), 32'd1);

        // 6b: clear coinciding with RESP beats the increment
        fork
            txn(32'h40, 32'h0, 4'h0, 0, 32'h11111111, 0);
            begin
                @(posedge clk); #1; cnt_clr = 1'b1;
                @(posedge clk); #1; cnt_clr = 1'b0;
            end
        join
        check("t6_clr_cnts", {rd_cnt | wr_cnt | err_cnt, 16'h0}, 32'h0);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
